key_expansion: RTL and testbench
================================

Name: key_expansion

Overview:
- AES key schedule block (FIPS-197) for the AES encrypt/decrypt datapath.
- Expands a 128/192/256-bit cipher key into all NR+1 round keys in a single step.
- The expansion logic is combinational and feeds one output register stage clocked by i_clk.
- Round-key consumers slice the registered flat bus.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8.
- NR, 10, number of rounds; legal pairs (NK,NR) = (4,10), (6,12), (8,14).

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst  input  1  asynchronous, active-high reset.
- i_cypher_key  input  32*NK  cipher key; first key byte in the MSBs.
- o_expanded_key  output  128*(NR+1)  registered expanded key, words w[0..4*(NR+1)-1].
- o_valid  output  1  high when o_expanded_key holds the expansion of a sampled key.

Behaviour:
- Word layout:
  - Let W = 128*(NR+1). Word w[i] occupies bits [W-1-32*i -: 32], so w[0] is in the MSBs.
  - Within a word, byte 0 is in the MSBs.
- Key words: w[0..NK-1] = i_cypher_key words in order, MSB word first. The output therefore starts with the key unchanged.
- For NK <= i < 4*(NR+1), with temp = w[i-1]:
  - if i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/NK], 24'h0}.
  - else if NK > 6 and i mod NK == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
- Word operations:
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the standard AES forward S-box to each of the 4 bytes.
- S-box: full 256-entry constant table, implemented inside this block as a function or case statement; no memory macros.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Only indices up to 4*(NR+1)/NK are used.
- Expansion path: purely combinational, built from a generate/for loop over word index, with no iterative state machine.
- Register stage: on each rising i_clk, o_expanded_key <= expansion(i_cypher_key) and o_valid <= 1.
- Latency: exactly 1 cycle from i_cypher_key to o_expanded_key.
  - The key may change every cycle; each new key's result appears on the following edge (throughput 1 key/cycle).
- Reset (asynchronous, immediate on i_rst assertion, including mid-operation):
  - o_expanded_key = 0 and o_valid = 0.
  - Both stay 0 while i_rst is high.
  - First edge after deassertion loads the expansion of the current key and sets o_valid = 1.
- X/illegal handling:
  - Unsupported (NK,NR) pairs are out of scope; simulation should flag them with a $error in an initial block.
  - No other error reporting.

Test Plan:
- AES-128 (NK=4,NR=10), key 2b7e151628aed2a6abf7158809cf4f3c, one clock after reset release -> w[0..3] = key, w[4]=a0fafe17, w[5]=88542cb1, w[43]=b6630ca6; full 1408-bit bus equals the FIPS-197 A.1 vector; o_valid=1.
- AES-256 (NK=8,NR=14), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w[8]=9ba35411, w[12]=a8b09c1a (SubWord-only path), w[59]=706c631e; full 1920-bit bus equals FIPS-197 A.3.
- AES-256, key 000102...1e1f -> w[8]=a573c29f, w[9]=a176c498, w[59]=6d68de36.
- AES-192 (NK=6,NR=12), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7, w[51]=01002202.
- Reset and back-to-back keys:
  - Assert i_rst asynchronously between edges while the output is valid -> o_expanded_key=0, o_valid=0 immediately, without waiting for a clock edge.
  - Release reset, apply a different key on each of two consecutive cycles -> each expansion appears exactly one edge later, in order.

Source files
------------

// File: rtl/key_expansion.sv
// AES key schedule: combinational expansion of a 128/192/256-bit key into all
// round keys, captured by a single output register stage.
module key_expansion #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [32*NK-1:0]        i_cypher_key,
    output logic [128*(NR+1)-1:0]   o_expanded_key,
    output logic                    o_valid
);

    localparam int NW = 4 * (NR + 1);
    localparam int W  = 32 * NW;

    // Forward S-box, entry 0 in the MSBs.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int j);
        logic [7:0] r;
        case (j)
            1:       r = 8'h01;
            2:       r = 8'h02;
            3:       r = 8'h04;
            4:       r = 8'h08;
            5:       r = 8'h10;
            6:       r = 8'h20;
            7:       r = 8'h40;
            8:       r = 8'h80;
            9:       r = 8'h1b;
            10:      r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    if (!((NK == 4 && NR == 10) || (NK == 6 && NR == 12) || (NK == 8 && NR == 14))) begin : g_bad_params
        $error("key_expansion: unsupported (NK,NR) = (%0d,%0d)", NK, NR);
    end

    logic [31:0]  w [NW];
    logic [W-1:0] expanded;

    // Each word only depends on earlier words, so the chain unrolls into pure logic.
    for (genvar i = 0; i < NW; i++) begin : g_word
        if (i < NK) begin : g_key
            assign w[i] = i_cypher_key[32*NK-1-32*i -: 32];
        end else if (i % NK == 0) begin : g_rot
            assign w[i] = w[i-NK] ^ sub_word({w[i-1][23:0], w[i-1][31:24]})
                        ^ {rcon(i / NK), 24'h0};
        end else if (NK > 6 && i % NK == 4) begin : g_sub
            assign w[i] = w[i-NK] ^ sub_word(w[i-1]);
        end else begin : g_xor
            assign w[i] = w[i-NK] ^ w[i-1];
        end
        assign expanded[W-1-32*i -: 32] = w[i];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_expanded_key <= '0;
            o_valid        <= 1'b0;
        end else begin
            o_expanded_key <= expanded;
            o_valid        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: three instances (AES-128/192/256) checked against a
// reference schedule whose S-box is derived from GF(2^8) inversion.
module tb_key_expansion;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [127:0]  key4 = '0;
    logic [191:0]  key6 = '0;
    logic [255:0]  key8 = '0;
    logic [1407:0] out4;
    logic [1663:0] out6;
    logic [1919:0] out8;
    logic          v4, v6, v8;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]    sb [256];
    logic [1919:0] exp4_q [$];
    logic [1919:0] exp6_q [$];
    logic [1919:0] exp8_q [$];

    always #5 clk = ~clk;

    key_expansion #(.NK(4), .NR(10)) dut4 (.i_clk(clk), .i_rst(rst), .i_cypher_key(key4),
                                           .o_expanded_key(out4), .o_valid(v4));
    key_expansion #(.NK(6), .NR(12)) dut6 (.i_clk(clk), .i_rst(rst), .i_cypher_key(key6),
                                           .o_expanded_key(out6), .o_valid(v6));
    key_expansion #(.NK(8), .NR(14)) dut8 (.i_clk(clk), .i_rst(rst), .i_cypher_key(key8),
                                           .o_expanded_key(out8), .o_valid(v8));

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] bx  = 8'(x);
            for (int y = 1; y < 256; y++)
                if (gmul(bx, 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [7:0] rc(input int j);
        logic [7:0] r = 8'h01;
        for (int k = 2; k <= j; k++) r = xtime(r);
        return r;
    endfunction

    // Reference schedule; key and result are right-aligned in the wide vectors.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [1919:0] res = '0;
        int nw = 4 * (nr + 1);
        for (int i = 0; i < nw; i++) begin
            if (i < nk) begin
                w[i] = key[32*nk-1-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0)
                    t = subw({t[23:0], t[31:24]}) ^ {rc(i / nk), 24'h0};
                else if (nk > 6 && i % nk == 4)
                    t = subw(t);
                w[i] = w[i-nk] ^ t;
            end
            res[32*nw-1-32*i -: 32] = w[i];
        end
        return res;
    endfunction

    function automatic logic [31:0] wd(input logic [1919:0] bus, input int nw, input int i);
        return bus[32*nw-1-32*i -: 32];
    endfunction

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic chkbus(input string tag, input logic [1919:0] got, input logic [1919:0] expv, input int nw);
        int idx = 0;
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            for (int i = nw - 1; i >= 0; i--)
                if (wd(got, nw, i) !== wd(expv, nw, i)) idx = i;
            $error("FAIL %s: word %0d got %h expected %h", tag, idx, wd(got, nw, idx), wd(expv, nw, idx));
        end
    endtask

    task automatic drive(input logic [127:0] k4, input logic [191:0] k6, input logic [255:0] k8);
        key4 = k4;
        key6 = k6;
        key8 = k8;
        exp4_q.push_back(expand({128'h0, k4}, 4, 10));
        exp6_q.push_back(expand({64'h0, k6}, 6, 12));
        exp8_q.push_back(expand(k8, 8, 14));
    endtask

    task automatic check_out(input string tag);
        if (exp4_q.size() == 0 || exp6_q.size() == 0 || exp8_q.size() == 0) begin
            chk32({tag, "_sb_underflow"}, 32'd0, 32'd1);
        end else begin
            chkbus({tag, "_bus128"}, {512'h0, out4}, exp4_q.pop_front(), 44);
            chkbus({tag, "_bus192"}, {256'h0, out6}, exp6_q.pop_front(), 52);
            chkbus({tag, "_bus256"}, out8, exp8_q.pop_front(), 60);
            chk32({tag, "_valid"}, {29'h0, v4, v6, v8}, 32'h7);
        end
    endtask

    task automatic check_zero(input string tag);
        chkbus({tag, "_bus128"}, {512'h0, out4}, '0, 44);
        chkbus({tag, "_bus192"}, {256'h0, out6}, '0, 52);
        chkbus({tag, "_bus256"}, out8, '0, 60);
        chk32({tag, "_valid"}, {29'h0, v4, v6, v8}, 32'h0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1919:0] b4, b6;
        build_sbox();

        repeat (2) @(posedge clk);
        #2 check_zero("reset");

        // Test-plan vectors, loaded on the first edge after reset release.
        @(negedge clk);
        rst = 1'b0;
        drive(128'h2b7e151628aed2a6abf7158809cf4f3c,
              192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
              256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        @(posedge clk);
        #2 check_out("fips");
        b4 = {512'h0, out4};
        b6 = {256'h0, out6};
        chk32("a128_key_w0", wd(b4, 44, 0), 32'h2b7e1516);
        chk32("a128_key_w3", wd(b4, 44, 3), 32'h09cf4f3c);
        chk32("a128_w4",  wd(b4, 44, 4),  32'ha0fafe17);
        chk32("a128_w5",  wd(b4, 44, 5),  32'h88542cb1);
        chk32("a128_w43", wd(b4, 44, 43), 32'hb6630ca6);
        chk32("a192_w6",  wd(b6, 52, 6),  32'hfe0c91f7);
        chk32("a192_w51", wd(b6, 52, 51), 32'h01002202);
        chk32("a256_w8",  wd(out8, 60, 8),  32'h9ba35411);
        chk32("a256_w12", wd(out8, 60, 12), 32'ha8b09c1a);
        chk32("a256_w59", wd(out8, 60, 59), 32'h706c631e);

        // Back-to-back: new keys on the very next cycle.
        @(negedge clk);
        drive(rnd128(), {rnd128(), 64'(rnd128())},
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        @(posedge clk);
        #2 check_out("seq256");
        chk32("seq256_w8",  wd(out8, 60, 8),  32'ha573c29f);
        chk32("seq256_w9",  wd(out8, 60, 9),  32'ha176c498);
        chk32("seq256_w59", wd(out8, 60, 59), 32'h6d68de36);

        // Asynchronous reset between edges while the output is valid.
        #1 rst = 1'b1;
        #1 check_zero("async_rst");
        @(posedge clk);
        #2 check_zero("rst_hold");

        @(negedge clk);
        rst = 1'b0;
        drive(rnd128(), {rnd128(), 64'(rnd128())}, {rnd128(), rnd128()});
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #2 check_out($sformatf("b2b%0d", c));
            @(negedge clk);
            drive(rnd128(), {rnd128(), 64'(rnd128())}, {rnd128(), rnd128()});
        end
        @(posedge clk);
        #2 check_out("b2b_last");
        chk32("sb_drained", exp4_q.size() + exp6_q.size() + exp8_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
